sar_cmp_ctrl: RTL and testbench

- Successive-approximation controller on the driving side of a 3-bit magnitude comparator (l/e/g outputs).
- The comparator's A input is an unknown value; this block drives the B input (trial) and reads back l/e/g.
- Resolves A MSB-first, exits early on equality, and flags illegal comparator codes.
- Used for threshold search and self-test of the comparator datapath.

---
 rtl/sar_cmp_pkg.sv | 23 ++
 rtl/sar_settle_cnt.sv | 36 +++
 rtl/sar_cmp_ctrl.sv | 159 +++++++++++++++
 tb/tb_sar_cmp_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sar_cmp_pkg.sv
// Shared types and constants for the successive-approximation comparator controller.
// Comparator codes are packed as {l,e,g}.
package sar_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        TEST,
        DONE
    } state_t;

    localparam int unsigned W_DEF      = 3;
    localparam int unsigned SETTLE_DEF = 0;

    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_GT = 3'b001;

    function automatic logic is_onehot3(input logic l, input logic e, input logic g);
        return ({l, e, g} == CMP_LT) || ({l, e, g} == CMP_EQ) || ({l, e, g} == CMP_GT);
    endfunction

endpackage

// File: rtl/sar_settle_cnt.sv
// Loadable down-counter that paces comparator settling; saturates at zero.
module sar_settle_cnt #(
    parameter int unsigned CW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sar_cmp_ctrl.sv
// Successive-approximation search that drives a comparator's B input and resolves
// its A input MSB-first, with early exit on equality and illegal-code detection.
module sar_cmp_ctrl
    import sar_cmp_pkg::*;
#(
    parameter int unsigned W      = W_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [W-1:0] trial,
    input  logic         cmp_l,
    input  logic         cmp_e,
    input  logic         cmp_g,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         early,
    output logic         err
);

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam state_t AFTER_LOAD = (SETTLE > 0) ? WAIT : TEST;

    state_t        state_q, state_d;
    logic [W-1:0]  trial_q, trial_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  result_q, result_d;
    logic [W-1:0]  nacc;
    logic [IW-1:0] idx_q, idx_d;
    logic          early_q, early_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt;
    logic [2:0]    code;

    generate
        if (SETTLE > 0) begin : g_settle
            sar_settle_cnt #(.CW(CW)) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .load     (cnt_load),
                .load_val (CW'(SETTLE)),
                .dec      (cnt_dec),
                .cnt      (cnt),
                .zero     (cnt_zero)
            );
        end else begin : g_no_settle
            logic unused_cnt_ctl;
            assign unused_cnt_ctl = cnt_load ^ cnt_dec;
            assign cnt            = '0;
            assign cnt_zero       = 1'b1;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        early_d  = early_q;
        err_d    = err_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        nacc     = acc_q;
        code     = {cmp_l, cmp_e, cmp_g};

        case (state_q)
            IDLE: begin
                if (start) begin
                    trial_d  = W'(1) << (W - 1);
                    acc_d    = '0;
                    idx_d    = IW'(W - 1);
                    cnt_load = 1'b1;
                    result_d = '0;
                    early_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = AFTER_LOAD;
                end
            end
            WAIT: begin
                cnt_dec = 1'b1;
                // zero only guards against a stuck counter; normal exit is at one
                if ((cnt == CW'(1)) || cnt_zero) begin
                    state_d = TEST;
                end
            end
            TEST: begin
                if (!is_onehot3(cmp_l, cmp_e, cmp_g)) begin
                    err_d    = 1'b1;
                    result_d = acc_q;
                    state_d  = DONE;
                end else if (code == CMP_EQ) begin
                    result_d = trial_q;
                    early_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    nacc = (code == CMP_GT) ? trial_q : acc_q;
                    if (idx_q == '0) begin
                        result_d = nacc;
                        state_d  = DONE;
                    end else begin
                        acc_d    = nacc;
                        trial_d  = nacc | (W'(1) << (idx_q - IW'(1)));
                        idx_d    = idx_q - IW'(1);
                        cnt_load = 1'b1;
                        state_d  = AFTER_LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == WAIT) || (state_d == TEST);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            acc_q    <= '0;
            idx_q    <= IW'(W - 1);
            result_q <= '0;
            early_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            early_q  <= early_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign trial  = trial_q;
    assign result = result_q;
    assign early  = early_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_sar_cmp_ctrl.sv
// Bench for sar_cmp_ctrl: two instances (SETTLE=0 and SETTLE=2), each driven by a
// behavioural comparator, with expectations queued at start and checked at done.
module tb_sar_cmp_ctrl;

    localparam int W = 3;

    typedef struct {
        int result;
        int early;
        int err;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start0, start2;
    logic [2:0] trial0, trial2, result0, result2;
    logic busy0, busy2, done0, done2, early0, early2, err0, err2;
    logic l0, e0, g0, l2, e2, g2;
    logic [2:0] a0, a2;
    logic ovr0;
    int sel_r;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sar_cmp_ctrl #(.W(3), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .trial(trial0),
        .cmp_l(l0), .cmp_e(e0), .cmp_g(g0),
        .busy(busy0), .done(done0), .result(result0), .early(early0), .err(err0)
    );

    sar_cmp_ctrl #(.W(3), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .trial(trial2),
        .cmp_l(l2), .cmp_e(e2), .cmp_g(g2),
        .busy(busy2), .done(done2), .result(result2), .early(early2), .err(err2)
    );

    // Behavioural comparators; dut0 can be forced to the illegal code 101
    always_comb begin
        if (ovr0) {l0, e0, g0} = 3'b101;
        else      {l0, e0, g0} = {a0 < trial0, a0 == trial0, a0 > trial0};
        {l2, e2, g2} = {a2 < trial2, a2 == trial2, a2 > trial2};
    end

    wire [2:0] trial_m  = (sel_r != 0) ? trial2  : trial0;
    wire [2:0] result_m = (sel_r != 0) ? result2 : result0;
    wire       busy_m   = (sel_r != 0) ? busy2   : busy0;
    wire       done_m   = (sel_r != 0) ? done2   : done0;
    wire       early_m  = (sel_r != 0) ? early2  : early0;
    wire       err_m    = (sel_r != 0) ? err2    : err0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start2 = v;
        else          start0 = v;
    endtask

    task automatic run(input int sel, input int a, input bit inj, input bit poke, input int rst_at);
        int st, k, lsb, cyc, ti, idx, t_exp;
        bit seen;
        exp_t e, g;
        st  = (sel != 0) ? 2 : 0;
        lsb = W;
        for (int b = W - 1; b >= 0; b--) if (a[b]) lsb = b;
        if (inj) begin
            e.result = 0; e.early = 0; e.err = 1; k = 1;
        end else begin
            e.result = a; e.early = (a != 0) ? 1 : 0; e.err = 0;
            k = (a == 0) ? W : W - lsb;
        end
        e.cyc = k * (st + 1) + 1;
        sb.push_back(e);

        @(negedge clk);
        sel_r = sel;
        if (sel != 0) a2 = 3'(a);
        else          a0 = 3'(a);
        ovr0 = inj;
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        cyc  = 1;
        seen = 0;
        while (cyc <= 40) begin
            if (rst_at == cyc) begin
                rst = 1'b1;
                #1;
                chk("rst_trial", int'(trial0), 0);
                chk("rst_busy", int'(busy0), 0);
                chk("rst_result", int'(result0), 0);
                chk("rst_flags", int'({done0, early0, err0}), 0);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("rst_no_done", int'(done0), 0);
                end
                @(negedge clk);
                rst = 1'b0;
                void'(sb.pop_front());
                return;
            end
            if (done_m) begin
                seen = 1;
                break;
            end
            ti    = (cyc - 1) / (st + 1);
            idx   = W - 1 - ti;
            t_exp = ((a >> (idx + 1)) << (idx + 1)) | (1 << idx);
            chk($sformatf("trial_a%0d_c%0d", a, cyc), int'(trial_m), t_exp);
            chk($sformatf("busy_a%0d_c%0d", a, cyc), int'(busy_m), 1);
            if (poke) set_start(sel, (cyc == 3) ? 1'b1 : 1'b0);
            @(posedge clk);
            #1;
            cyc++;
        end
        set_start(sel, 1'b0);
        g = sb.pop_front();
        if (!seen) begin
            chk($sformatf("timeout_a%0d", a), 0, 1);
            return;
        end
        chk($sformatf("done_cyc_a%0d", a), cyc, g.cyc);
        chk($sformatf("result_a%0d", a), int'(result_m), g.result);
        chk($sformatf("early_a%0d", a), int'(early_m), g.early);
        chk($sformatf("err_a%0d", a), int'(err_m), g.err);
        chk($sformatf("busy_at_done_a%0d", a), int'(busy_m), 0);
        @(posedge clk);
        #1;
        ovr0 = 1'b0;
        chk($sformatf("done_pulse_a%0d", a), int'(done_m), 0);
        chk($sformatf("result_held_a%0d", a), int'(result_m), g.result);
        chk($sformatf("err_held_a%0d", a), int'(err_m), g.err);
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        a0     = '0;
        a2     = '0;
        ovr0   = 1'b0;
        sel_r  = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_trial0", int'(trial0), 0);
        chk("reset_out0", int'({busy0, done0, early0, err0, result0}), 0);
        chk("reset_out2", int'({trial2, busy2, done2, early2, err2, result2}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Full sweep with immediate sampling (covers A=5, A=0 and the A=4 one-shot case)
        for (int a = 0; a < 8; a++) run(0, a, 0, 0, 0);

        // Illegal comparator code on the first test, then a clean search clears err
        run(0, 0, 1, 0, 0);
        run(0, 3, 0, 0, 0);

        // Settling delay with start pokes during busy
        run(1, 3, 0, 1, 0);
        run(1, 0, 0, 0, 0);
        run(1, 7, 0, 1, 0);

        // Reset mid-search, then restart
        run(0, 6, 0, 0, 2);
        run(0, 6, 0, 0, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
